// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler feeding two requesters into the shared y_f exponent shifter,
// capturing its result in a one-entry valid/ready output slot with saturating grant counters.
module shift_sched #(
    parameter int DW = 20,
    parameter int EW = 5,
    parameter int RW = 23,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    input  logic [EW-1:0] req0_exp,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    input  logic [EW-1:0] req1_exp,
    output logic          req1_ready,
    output logic [DW-1:0] sh_data,
    output logic [EW-1:0] sh_exp,
    input  logic [RW-1:0] sh_result,
    output logic          out_valid,
    output logic [RW-1:0] out_data,
    output logic          out_tag,
    output logic          out_err,
    input  logic          out_ready,
    input  logic          clr_cnt,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic signed [EW-1:0] EXP_MAX = EW'(3);
    localparam logic signed [EW-1:0] EXP_MIN = EW'(-12);

    logic [0:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic          out_tag_q, out_tag_d;
    logic          out_err_q, out_err_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic          slot_free, winner, accept, exp_bad;

    always_comb begin
        slot_free    = state_q == EMPTY || out_ready;
        winner       = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
        req0_ready   = !winner && req0_valid && slot_free;
        req1_ready   = winner && req1_valid && slot_free;
        accept       = req0_ready || req1_ready;
        sh_data      = !(req0_valid || req1_valid) ? '0 : winner ? req1_data : req0_data;
        sh_exp       = !(req0_valid || req1_valid) ? '0 : winner ? req1_exp : req0_exp;
        exp_bad      = $signed(sh_exp) > EXP_MAX || $signed(sh_exp) < EXP_MIN;
        state_d      = accept ? FULL : out_ready ? EMPTY : state_q;
        last_grant_d = accept ? winner : last_grant_q;
        out_data_d   = accept ? sh_result : out_data_q;
        out_tag_d    = accept ? winner : out_tag_q;
        out_err_d    = accept ? exp_bad : out_err_q;
        // clear wins over a coincident accept
        cnt0_d       = clr_cnt ? '0 : (req0_ready && cnt0_q != '1) ? cnt0_q + CW'(1) : cnt0_q;
        cnt1_d       = clr_cnt ? '0 : (req1_ready && cnt1_q != '1) ? cnt1_q + CW'(1) : cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            out_data_q   <= '0;
            out_tag_q    <= 1'b0;
            out_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out_valid = state_q == FULL;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed plan scenarios plus random traffic against a behavioural scheduler model.
module tb_shift_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [19:0] req0_data = '0, req1_data = '0;
    logic [4:0]  req0_exp = '0, req1_exp = '0;
    logic        req0_ready, req1_ready;
    logic [19:0] sh_data;
    logic [4:0]  sh_exp;
    logic [22:0] sh_result;
    logic        out_valid, out_tag, out_err;
    logic [22:0] out_data;
    logic        out_ready = 1'b0, clr_cnt = 1'b0;
    logic [15:0] cnt0, cnt1;

    int errors = 0, checks = 0;
    int m_last, m_valid, m_data, m_tag, m_err, m_cnt0, m_cnt1;
    bit h0, h1;
    logic [22:0] saved;

    shift_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_exp(req0_exp), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_exp(req1_exp), .req1_ready(req1_ready),
        .sh_data(sh_data), .sh_exp(sh_exp), .sh_result(sh_result),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
        .out_ready(out_ready), .clr_cnt(clr_cnt), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    // external combinational shifter
    function automatic logic [22:0] shifter(input logic [19:0] d, input logic [4:0] e);
        logic [22:0] z;
        z = {3'b000, d};
        if (e >= 5'd4 && e <= 5'd19) return z;
        return e[4] ? z >> (6'd32 - {1'b0, e}) : z << e;
    endfunction

    assign sh_result = shifter(sh_data, sh_exp);

    function automatic int sexp(input int e);
        return e >= 16 ? e - 32 : e;
    endfunction

    function automatic int illegal(input int e);
        return (sexp(e) > 3 || sexp(e) < -12) ? 1 : 0;
    endfunction

    function automatic int ref_shift(input int d, input int e);
        if (illegal(e) != 0) return d;
        if (sexp(e) >= 0) return d * (1 << sexp(e));
        return d / (1 << -sexp(e));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_valid = 0; m_data = 0; m_tag = 0; m_err = 0; m_cnt0 = 0; m_cnt1 = 0;
        h0 = 0; h1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        int w, r0, r1, any, ed, ee;
        #1;
        any = (req0_valid || req1_valid) ? 1 : 0;
        w = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
        r0 = (req0_valid && w == 0 && (m_valid == 0 || out_ready)) ? 1 : 0;
        r1 = (req1_valid && w == 1 && (m_valid == 0 || out_ready)) ? 1 : 0;
        ed = any == 0 ? 0 : (w == 1 ? int'(req1_data) : int'(req0_data));
        ee = any == 0 ? 0 : (w == 1 ? int'(req1_exp) : int'(req0_exp));
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        chk("sh_data", sh_data, ed);
        chk("sh_exp", sh_exp, ee);
        @(posedge clk);
        if (r0 + r1 > 0) begin
            m_valid = 1; m_data = ref_shift(ed, ee); m_tag = w; m_err = illegal(ee); m_last = w;
        end else if (out_ready) m_valid = 0;
        m_cnt0 = clr_cnt ? 0 : (r0 == 1 && m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
        m_cnt1 = clr_cnt ? 0 : (r1 == 1 && m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
        h0 = req0_valid && r0 == 0;
        h1 = req1_valid && r1 == 0;
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_tag", out_tag, m_tag);
        chk("out_err", out_err, m_err);
        chk("cnt0", cnt0, m_cnt0);
        chk("cnt1", cnt1, m_cnt1);
    endtask

    function automatic logic [4:0] rand_exp();
        return ($urandom_range(0, 4) == 0) ? 5'($urandom_range(4, 19)) : 5'(($urandom_range(0, 15) + 20) % 32);
    endfunction

    initial begin
        model_reset();
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // single request into an idle slot
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 20'h00001; req0_exp = 5'b00011;
        #1 chk("single_ready", req0_ready, 1);
        cycle();
        chk("single_data", out_data, 23'h000008);
        chk("single_tag", out_tag, 0);
        chk("single_cnt0", cnt0, 1);

        // contention from reset: grants alternate starting with port 0
        do_reset();
        req0_valid = 1'b1; req0_data = 20'h80000; req0_exp = 5'b00000;
        req1_valid = 1'b1; req1_data = 20'h80000; req1_exp = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("cont_tag", out_tag, i % 2);
            chk("cont_data", out_data, (i % 2) != 0 ? 23'h040000 : 23'h080000);
        end
        chk("cont_cnt0", cnt0, 2);
        chk("cont_cnt1", cnt1, 2);

        // backpressure on a full slot
        req0_valid = 1'b0;
        req1_data = 20'h12345; req1_exp = 5'b00010;
        out_ready = 1'b0;
        saved = out_data;
        repeat (5) begin
            cycle();
            chk("bp_ready", req1_ready, 0);
            chk("bp_hold", out_data, saved);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_accept_data", out_data, 23'h048D14);
        chk("bp_accept_tag", out_tag, 1);

        // illegal exponent passes data through and flags it
        req1_data = 20'hFFFFF; req1_exp = 5'b10011;
        cycle();
        chk("ill_data", out_data, 23'h0FFFFF);
        chk("ill_err", out_err, 1);
        chk("ill_tag", out_tag, 1);
        req1_data = 20'h00005; req1_exp = 5'b00000;
        cycle();
        chk("ill_clear", out_err, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!h0) begin
                req0_valid = $urandom_range(0, 3) != 0;
                req0_data = 20'($urandom);
                req0_exp = rand_exp();
            end
            if (!h1) begin
                req1_valid = $urandom_range(0, 3) != 0;
                req1_data = 20'($urandom);
                req1_exp = rand_exp();
            end
            out_ready = $urandom_range(0, 2) != 0;
            clr_cnt = $urandom_range(0, 49) == 0;
            cycle();
        end
        clr_cnt = 1'b0;

        // reset while full with a request pending
        out_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0; req0_exp = 5'b00001;
        cycle();
        cycle();
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_cnt0", cnt0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; req1_valid = 1'b1;
        #1 chk("post_rst_grant0", req0_ready, 1);
        cycle();
        chk("post_rst_tag", out_tag, 0);

        // counter saturation and clear priority
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (65535) cycle();
        chk("sat_full", cnt0, 16'hFFFF);
        cycle();
        chk("sat_hold", cnt0, 16'hFFFF);
        clr_cnt = 1'b1;
        cycle();
        chk("clr_accept", cnt0, 0);
        clr_cnt = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
